// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - N-layer priority pixel compositor with colour-key transparency and per-frame collision flags
// Optional flash override on player collision is enabled by defining COMPOSITOR_FLASH_EN.
module sprite_compositor #(
  parameter int                  N_LAYERS   = 12,
  parameter logic [11:0]         KEY_COLOR  = 12'hF0F,
  parameter logic [N_LAYERS-1:0] FLASH_MASK = '0,
  parameter logic [11:0]         FLASH_RGB  = 12'hFFF,
  parameter int                  FLASH_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bright,
  input  logic                    frame_start,
  input  logic [N_LAYERS-1:0]     layer_en,
  input  logic [12*N_LAYERS-1:0]  layer_rgb,
  input  logic [11:0]             bg_rgb,
  output logic [11:0]             vga_rgb,
  output logic [N_LAYERS-1:0]     collision_flags,
  output logic                    collision_valid
);

  logic                   bright_q, bright_d;
  logic                   frame_start_q, frame_start_d;
  logic [N_LAYERS-1:0]    layer_en_q, layer_en_d;
  logic [12*N_LAYERS-1:0] layer_rgb_q, layer_rgb_d;
  logic [11:0]            bg_rgb_q, bg_rgb_d;

  logic [11:0]            vga_rgb_q, vga_rgb_d;
  logic [N_LAYERS-1:0]    acc_q, acc_d;
  logic [N_LAYERS-1:0]    flags_q, flags_d;
  logic                   valid_q, valid_d;

  logic [N_LAYERS-1:0]    opaque;
  logic [N_LAYERS-1:0]    hits;
  logic [11:0]            prio_rgb;

`ifdef COMPOSITOR_FLASH_EN
  localparam int CW = FLASH_LOG2 + 1;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
`else
  logic unused_flash_cfg;
  assign unused_flash_cfg = ^{FLASH_MASK, FLASH_RGB, FLASH_LOG2};
`endif

  always_comb begin
    bright_d      = bright;
    frame_start_d = frame_start;
    layer_en_d    = layer_en;
    layer_rgb_d   = layer_rgb;
    bg_rgb_d      = bg_rgb;

    opaque   = '0;
    prio_rgb = bg_rgb_q;
    // Ascending scan: the last opaque layer seen is the highest-priority one.
    for (int i = 0; i < N_LAYERS; i++) begin
      opaque[i] = layer_en_q[i] && (layer_rgb_q[12*i +: 12] != KEY_COLOR);
      if (opaque[i]) prio_rgb = layer_rgb_q[12*i +: 12];
    end

    hits    = opaque & {N_LAYERS{bright_q & opaque[0]}};
    hits[0] = 1'b0;

    vga_rgb_d = bright_q ? prio_rgb : 12'h000;

`ifdef COMPOSITOR_FLASH_EN
    frame_cnt_d = frame_cnt_q + CW'(frame_start_q);
    if (bright_q && opaque[0] && |(opaque & FLASH_MASK) && frame_cnt_q[CW-1])
      vga_rgb_d = FLASH_RGB;
`endif

    // The frame_start pixel already belongs to the new frame, so its hits seed the accumulator.
    if (frame_start_q) begin
      flags_d = acc_q;
      acc_d   = hits;
      valid_d = 1'b1;
    end else begin
      flags_d = flags_q;
      acc_d   = acc_q | hits;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright_q      <= 1'b0;
      frame_start_q <= 1'b0;
      layer_en_q    <= '0;
      layer_rgb_q   <= '0;
      bg_rgb_q      <= '0;
      vga_rgb_q     <= '0;
      acc_q         <= '0;
      flags_q       <= '0;
      valid_q       <= 1'b0;
    end else begin
      bright_q      <= bright_d;
      frame_start_q <= frame_start_d;
      layer_en_q    <= layer_en_d;
      layer_rgb_q   <= layer_rgb_d;
      bg_rgb_q      <= bg_rgb_d;
      vga_rgb_q     <= vga_rgb_d;
      acc_q         <= acc_d;
      flags_q       <= flags_d;
      valid_q       <= valid_d;
    end
  end

`ifdef COMPOSITOR_FLASH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end
`endif

  assign vga_rgb         = vga_rgb_q;
  assign collision_flags = flags_q;
  assign collision_valid = valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed self-checking bench for sprite_compositor
module tb_sprite_compositor;

  localparam int N = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic            bright;
  logic            frame_start;
  logic [N-1:0]    layer_en;
  logic [12*N-1:0] layer_rgb;
  logic [11:0]     bg_rgb;
  logic [11:0]     vga_rgb;
  logic [N-1:0]    collision_flags;
  logic            collision_valid;

  int errors = 0;
  int checks = 0;
  int fs_count = 0;

  sprite_compositor #(
    .N_LAYERS   (N),
    .KEY_COLOR  (12'hF0F),
    .FLASH_MASK (12'h010),
    .FLASH_RGB  (12'hFFF),
    .FLASH_LOG2 (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bright          (bright),
    .frame_start     (frame_start),
    .layer_en        (layer_en),
    .layer_rgb       (layer_rgb),
    .bg_rgb          (bg_rgb),
    .vga_rgb         (vga_rgb),
    .collision_flags (collision_flags),
    .collision_valid (collision_valid)
  );

  always #5 clk = ~clk;

  task automatic set_layer(input int idx, input logic en, input logic [11:0] rgb);
    layer_en[idx]            = en;
    layer_rgb[12*idx +: 12] = rgb;
  endtask

  task automatic clear_layers();
    layer_en  = '0;
    layer_rgb = '0;
  endtask

  // Called at a negedge; returns at the following negedge with frame_start dropped.
  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fs_count++;
  endtask

  task automatic test_reset();
    reset = 1'b1; bright = 1'b0; frame_start = 1'b0; bg_rgb = '0;
    clear_layers();
    repeat (3) @(negedge clk);
    checks++; if (vga_rgb !== 12'h000) begin errors++; $display("FAIL reset_vga got=%h exp=%h", vga_rgb, 12'h000); end
    checks++; if (collision_flags !== 12'h000) begin errors++; $display("FAIL reset_flags got=%h exp=%h", collision_flags, 12'h000); end
    checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", collision_valid); end
    reset = 1'b0; bright = 1'b1; bg_rgb = 12'h69C;
    set_layer(0, 1'b1, 12'h00F);
    set_layer(1, 1'b1, 12'h0A0);
    repeat (2) @(negedge clk);
    checks++; if (vga_rgb !== 12'h0A0) begin errors++; $display("FAIL pre_reset_vga got=%h exp=%h", vga_rgb, 12'h0A0); end
    pulse_frame();
    @(negedge clk);
    checks++; if (collision_flags !== 12'h002 || collision_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_flags got=%h/%b exp=002/1", collision_flags, collision_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (vga_rgb !== 12'h000 || collision_flags !== 12'h000 || collision_valid !== 1'b0) begin
      errors++; $display("FAIL midstream_reset got=%h/%h/%b exp=000/000/0", vga_rgb, collision_flags, collision_valid);
    end
    @(negedge clk);
    reset = 1'b0; fs_count = 0;
    clear_layers();
    repeat (2) @(negedge clk);
    checks++; if (vga_rgb !== 12'h69C) begin errors++; $display("FAIL post_reset_bg got=%h exp=%h", vga_rgb, 12'h69C); end
    set_layer(0, 1'b1, 12'h00F);
    set_layer(6, 1'b1, 12'h606);
    @(negedge clk);
    clear_layers();
    pulse_frame();
    @(negedge clk);
    checks++; if (collision_flags !== 12'h040 || collision_valid !== 1'b1) begin
      errors++; $display("FAIL partial_frame got=%h/%b exp=040/1", collision_flags, collision_valid);
    end
  endtask

  task automatic test_priority();
    set_layer(0, 1'b1, 12'h00F);
    set_layer(5, 1'b1, 12'hF00);
    @(negedge clk);
    checks++; if (vga_rgb !== 12'h69C) begin errors++; $display("FAIL latency_one_clk got=%h exp=%h", vga_rgb, 12'h69C); end
    @(negedge clk);
    checks++; if (vga_rgb !== 12'hF00) begin errors++; $display("FAIL prio_l5_over_l0 got=%h exp=%h", vga_rgb, 12'hF00); end
    set_layer(5, 1'b0, 12'hF00);
    repeat (2) @(negedge clk);
    checks++; if (vga_rgb !== 12'h00F) begin errors++; $display("FAIL prio_drop_l5 got=%h exp=%h", vga_rgb, 12'h00F); end
    set_layer(11, 1'b1, 12'h123);
    set_layer(5, 1'b1, 12'hF00);
    repeat (2) @(negedge clk);
    checks++; if (vga_rgb !== 12'h123) begin errors++; $display("FAIL prio_top_layer got=%h exp=%h", vga_rgb, 12'h123); end
    clear_layers();
  endtask

  task automatic test_key();
    pulse_frame();
    @(negedge clk);
    checks++; if (collision_flags !== 12'h820 || collision_valid !== 1'b1) begin
      errors++; $display("FAIL flags_prev_frame got=%h/%b exp=820/1", collision_flags, collision_valid);
    end
    @(negedge clk);
    checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got=%b exp=0", collision_valid); end
    set_layer(0, 1'b1, 12'h0F0);
    set_layer(5, 1'b1, 12'hF0F);
    repeat (2) @(negedge clk);
    checks++; if (vga_rgb !== 12'h0F0) begin errors++; $display("FAIL key_fallthrough got=%h exp=%h", vga_rgb, 12'h0F0); end
    set_layer(0, 1'b0, 12'h0F0);
    repeat (2) @(negedge clk);
    checks++; if (vga_rgb !== 12'h69C) begin errors++; $display("FAIL key_to_bg got=%h exp=%h", vga_rgb, 12'h69C); end
    clear_layers();
    pulse_frame();
    @(negedge clk);
    checks++; if (collision_flags !== 12'h000 || collision_valid !== 1'b1) begin
      errors++; $display("FAIL key_no_collision got=%h/%b exp=000/1", collision_flags, collision_valid);
    end
  endtask

  task automatic test_collision();
    bright = 1'b0;
    set_layer(0, 1'b1, 12'h00F);
    set_layer(7, 1'b1, 12'h777);
    repeat (3) @(negedge clk);
    bright = 1'b1;
    clear_layers();
    set_layer(0, 1'b1, 12'h00F);
    set_layer(3, 1'b1, 12'h333);
    @(negedge clk);
    clear_layers();
    repeat (3) @(negedge clk);
    pulse_frame();
    checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL valid_before_publish got=%b exp=0", collision_valid); end
    @(negedge clk);
    checks++; if (collision_flags !== 12'h008 || collision_valid !== 1'b1) begin
      errors++; $display("FAIL one_pixel_overlap got=%h/%b exp=008/1", collision_flags, collision_valid);
    end
    @(negedge clk);
    checks++; if (collision_flags !== 12'h008 || collision_valid !== 1'b0) begin
      errors++; $display("FAIL flags_hold got=%h/%b exp=008/0", collision_flags, collision_valid);
    end
    repeat (3) @(negedge clk);
    pulse_frame();
    @(negedge clk);
    checks++; if (collision_flags !== 12'h000 || collision_valid !== 1'b1) begin
      errors++; $display("FAIL clean_frame got=%h/%b exp=000/1", collision_flags, collision_valid);
    end
  endtask

  task automatic test_back_to_back();
    frame_start = 1'b1;
    set_layer(0, 1'b1, 12'h00F);
    set_layer(2, 1'b1, 12'h222);
    @(negedge clk);
    clear_layers();
    @(negedge clk);
    checks++; if (collision_flags !== 12'h000 || collision_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got=%h/%b exp=000/1", collision_flags, collision_valid);
    end
    frame_start = 1'b0;
    fs_count += 2;
    @(negedge clk);
    checks++; if (collision_flags !== 12'h004 || collision_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second got=%h/%b exp=004/1", collision_flags, collision_valid);
    end
    @(negedge clk);
    checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got=%b exp=0", collision_valid); end
    pulse_frame();
    @(negedge clk);
    checks++; if (collision_flags !== 12'h000) begin errors++; $display("FAIL b2b_after got=%h exp=%h", collision_flags, 12'h000); end
  endtask

  task automatic test_blank();
    bright = 1'b0;
    for (int i = 0; i < N; i++) set_layer(i, 1'b1, 12'(i * 12'h111));
    repeat (3) @(negedge clk);
    checks++; if (vga_rgb !== 12'h000) begin errors++; $display("FAIL blank_black got=%h exp=%h", vga_rgb, 12'h000); end
    clear_layers();
    pulse_frame();
    @(negedge clk);
    checks++; if (collision_flags !== 12'h000) begin errors++; $display("FAIL blank_no_acc got=%h exp=%h", collision_flags, 12'h000); end
    bright = 1'b1;
    for (int i = 0; i < N; i++) set_layer(i, 1'b1, 12'(i * 12'h111));
    repeat (2) @(negedge clk);
    checks++; if (vga_rgb !== 12'hBBB) begin errors++; $display("FAIL all_on_top got=%h exp=%h", vga_rgb, 12'hBBB); end
    clear_layers();
    pulse_frame();
    @(negedge clk);
    checks++; if (collision_flags !== 12'hFFE) begin errors++; $display("FAIL all_overlap got=%h exp=%h", collision_flags, 12'hFFE); end
  endtask

  task automatic test_flash();
    logic [11:0] exp;
    bright = 1'b1;
    set_layer(0, 1'b1, 12'h00F);
    set_layer(4, 1'b1, 12'h4A4);
    for (int k = 0; k < 4; k++) begin
      pulse_frame();
      repeat (2) @(negedge clk);
`ifdef COMPOSITOR_FLASH_EN
      exp = (((fs_count >> 1) & 1) != 0) ? 12'hFFF : 12'h4A4;
`else
      exp = 12'h4A4;
`endif
      checks++; if (vga_rgb !== exp) begin errors++; $display("FAIL flash_frame%0d got=%h exp=%h", k, vga_rgb, exp); end
    end
    clear_layers();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_key();
    test_collision();
    test_back_to_back();
    test_blank();
    test_flash();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
